seg7_scan_driver: RTL and testbench

Downstream display stage of the digital clock top level. Takes the four 4-bit display digits produced by the display-mode mux (hours/minutes, month/day, or stopwatch), the per-digit decimal-point enables and the edit-blink mask, and time-multiplexes them onto a common-anode 4-digit 7-segment display. Inputs are snapshotted once per frame so a scan never shows a torn value. Each digit slot starts with an anti-ghosting guard interval during which all anodes are off.

---
 rtl/clock_disp_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 28 ++
 rtl/seg7_scan_driver.sv | 112 +++++++++++
 tb/tb_seg7_scan_driver.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the clock display path.
// Segment patterns are active low, bit 0 = segment a ... bit 6 = segment g.
package clock_disp_pkg;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    digit_t [3:0] digit;
    logic [3:0]   dp_en;
    logic [3:0]   blink_mask;
    logic         blank_lead;
  } frame_t;

  localparam int SCAN_DIV_DEFAULT  = 100000;
  localparam int GUARD_DEFAULT     = 2000;
  localparam int BLINK_DIV_DEFAULT = 25000000;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam digit_t DIGIT_BLANK = 4'hF;

  localparam frame_t FRAME_RESET = '{
    digit:      {4{DIGIT_BLANK}},
    dp_en:      4'h0,
    blink_mask: 4'h0,
    blank_lead: 1'b0
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit to active-low 7-segment decoder.
// 0xA..0xE render as a dash (error glyph), 0xF renders blank.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit scan driver with per-frame input
// snapshot, anti-ghosting guard interval, leading-zero blanking and edit blink.
module seg7_scan_driver
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
  parameter int GUARD     = GUARD_DEFAULT,
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_en,
  input  logic [3:0] blink_mask,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD  = CW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  frame_t        shadow;

  digit_t     cur_digit;
  logic [6:0] cur_seg;
  logic       cur_blinked;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  // Leading-zero suppression is applied before decode so dp stays independent.
  always_comb begin
    cur_digit = shadow.digit[idx];
    if ((idx == 2'd0) && shadow.blank_lead && (shadow.digit[0] == 4'h0)) begin
      cur_digit = DIGIT_BLANK;
    end
  end

  seg7_decode u_decode (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  assign cur_blinked = shadow.blink_mask[idx] & ~blink_on;

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (cnt >= CNT_GUARD) begin
      an_nxt[idx] = 1'b0;
      if (!cur_blinked) begin
        seg_nxt = cur_seg;
        dp_nxt  = ~shadow.dp_en[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= 2'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      shadow    <= FRAME_RESET;
      an        <= 4'b1111;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end

      // Frame start: latch the whole input set so a scan never tears.
      if ((cnt == '0) && (idx == 2'd0)) begin
        shadow <= '{
          digit:      {digit3, digit2, digit1, digit0},
          dp_en:      dp_en,
          blink_mask: blink_mask,
          blank_lead: blank_lead
        };
      end

      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a time-indexed reference
// model derived from the scan schedule, frame snapshot and blink period.
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BD = 64;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit0 = 4'h0, digit1 = 4'h0, digit2 = 4'h0, digit3 = 4'h0;
  logic [3:0] dp_en = 4'h0, blink_mask = 4'h0;
  logic       blank_lead = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // Reference model state: m_pos = clock edges since reset release.
  int         m_pos = 0;
  int         m_sd[4] = '{15, 15, 15, 15};
  logic [3:0] m_dpen = 4'h0, m_mask = 4'h0;
  logic       m_bl = 1'b0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;

  seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .dp_en      (dp_en),
    .blink_mask (blink_mask),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10, 11, 12, 13, 14: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit ref_dark(int p);
    int d = (p / SD) % 4;
    return ((p % SD) < GD) || (m_mask[d] && ((p / BD) % 2 == 1));
  endfunction

  function automatic logic [3:0] ref_an(int p);
    if ((p % SD) < GD) return 4'b1111;
    return ~(4'b0001 << ((p / SD) % 4));
  endfunction

  function automatic logic [6:0] ref_seg(int p);
    int d = (p / SD) % 4;
    if (ref_dark(p)) return 7'h7F;
    if (d == 0 && m_bl && m_sd[0] == 0) return 7'h7F;
    return glyph(m_sd[d]);
  endfunction

  function automatic logic ref_dp(int p);
    int d = (p / SD) % 4;
    if (ref_dark(p)) return 1'b1;
    return ~m_dpen[d];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos  <= 0;
      m_sd   <= '{15, 15, 15, 15};
      m_dpen <= 4'h0;
      m_mask <= 4'h0;
      m_bl   <= 1'b0;
      m_an   <= 4'hF;
      m_seg  <= 7'h7F;
      m_dp   <= 1'b1;
    end else begin
      m_an  <= ref_an(m_pos);
      m_seg <= ref_seg(m_pos);
      m_dp  <= ref_dp(m_pos);
      if (m_pos % FRAME == 0) begin
        m_sd   <= '{int'(digit0), int'(digit1), int'(digit2), int'(digit3)};
        m_dpen <= dp_en;
        m_mask <= blink_mask;
        m_bl   <= blank_lead;
      end
      m_pos <= m_pos + 1;
    end
  end

  task automatic test_reset();
    digit0 = 4'($urandom); digit1 = 4'($urandom);
    digit2 = 4'($urandom); digit3 = 4'($urandom);
    dp_en = 4'($urandom); blink_mask = 4'($urandom); blank_lead = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    checks++;
    if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
      errors++;
      $display("FAIL reset_model an=%b seg=%b dp=%b expected %b %b %b", an, seg, dp, m_an, m_seg, m_dp);
    end
  endtask

  task automatic test_first_frame();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int kk;
    digit0 = 4'd1; digit1 = 4'd2; digit2 = 4'd3; digit3 = 4'd4;
    dp_en = 4'h0; blink_mask = 4'h0; blank_lead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      kk = (k - 1) % FRAME + 1;
      checks++;
      if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
        errors++;
        $display("FAIL first_frame_model k=%0d an=%b seg=%b dp=%b expected %b %b %b", k, an, seg, dp, m_an, m_seg, m_dp);
      end
      if (kk <= 16) begin
        if (kk <= 2)       begin e_an = 4'b1111; e_seg = 7'h7F; end
        else if (kk <= 8)  begin e_an = 4'b1110; e_seg = 7'b1111001; end
        else if (kk <= 10) begin e_an = 4'b1111; e_seg = 7'h7F; end
        else               begin e_an = 4'b1101; e_seg = 7'b0100100; end
        checks++;
        if (an !== e_an || seg !== e_seg || dp !== 1'b1) begin
          errors++;
          $display("FAIL first_frame_seq k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=1", k, an, seg, dp, e_an, e_seg);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int guard = 0;
    int n3 = 0;
    int n7 = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (m_pos % FRAME != SD + 3 && guard < 100);
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL snapshot_wait timeout pos=%0d required slot1 cnt3", m_pos);
    end
    digit2 = 4'd7;
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
        errors++;
        $display("FAIL snapshot_model j=%0d an=%b seg=%b dp=%b expected %b %b %b", j, an, seg, dp, m_an, m_seg, m_dp);
      end
      if (an === 4'b1011) begin
        if (j < 32 && seg === 7'b0110000) n3++;
        if (j >= 32 && seg === 7'b1111000) n7++;
      end
    end
    checks++;
    if (n3 != 6 || n7 != 6) begin
      errors++;
      $display("FAIL snapshot_tearing old_glyph_cycles=%0d new_glyph_cycles=%0d expected 6 and 6", n3, n7);
    end
  endtask

  task automatic test_blank_lead();
    int guard = 0;
    logic [6:0] e_seg;
    logic e_dp;
    digit0 = 4'd0; digit1 = 4'd5; digit2 = 4'hA; digit3 = 4'hF;
    dp_en = 4'b0010; blank_lead = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (m_pos % FRAME != 1 && guard < 100);
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL blank_lead_wait timeout pos=%0d", m_pos);
    end
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
        errors++;
        $display("FAIL blank_lead_model j=%0d an=%b seg=%b dp=%b expected %b %b %b", j, an, seg, dp, m_an, m_seg, m_dp);
      end
      e_dp = 1'b1;
      case (an)
        4'b1101: begin e_seg = 7'b0010010; e_dp = 1'b0; end
        4'b1011: e_seg = 7'b0111111;
        default: e_seg = 7'h7F;
      endcase
      checks++;
      if (seg !== e_seg || dp !== e_dp) begin
        errors++;
        $display("FAIL blank_lead_glyph j=%0d an=%b seg=%b dp=%b expected seg=%b dp=%b", j, an, seg, dp, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_blink();
    int n_slot0 = 0;
    int p;
    digit0 = 4'd1; digit1 = 4'd2; digit2 = 4'd3; digit3 = 4'd4;
    dp_en = 4'b1111; blink_mask = 4'b0011; blank_lead = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 2 * BD; k++) begin
      @(negedge clk);
      p = k - 1;
      checks++;
      if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
        errors++;
        $display("FAIL blink_model k=%0d an=%b seg=%b dp=%b expected %b %b %b", k, an, seg, dp, m_an, m_seg, m_dp);
      end
      if (an !== 4'b1111) begin
        checks++;
        if (p >= BD && (an[0] === 1'b0 || an[1] === 1'b0)) begin
          if (an === 4'b1110) n_slot0++;
          if (seg !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL blink_off k=%0d an=%b seg=%b dp=%b expected seg=1111111 dp=1", k, an, seg, dp);
          end
        end else if (seg === 7'h7F || dp !== 1'b0) begin
          errors++;
          $display("FAIL blink_lit k=%0d an=%b seg=%b dp=%b expected lit glyph dp=0", k, an, seg, dp);
        end
      end
    end
    checks++;
    if (n_slot0 != 12) begin
      errors++;
      $display("FAIL blink_anode_pulses an0_low=%0d expected 12", n_slot0);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    digit0 = 4'd1; digit1 = 4'd2; digit2 = 4'd3; digit3 = 4'd4;
    dp_en = 4'h0; blink_mask = 4'h0;
    do begin
      @(negedge clk);
      guard++;
    end while (m_pos % FRAME != 2 * SD + 5 && guard < 100);
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL reset_mid_wait timeout pos=%0d", m_pos);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_blank an=%b seg=%b dp=%b expected 1111 1111111 1", an, seg, dp);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 2)       begin e_an = 4'b1111; e_seg = 7'h7F; end
      else if (k <= 8)  begin e_an = 4'b1110; e_seg = 7'b1111001; end
      else if (k <= 10) begin e_an = 4'b1111; e_seg = 7'h7F; end
      else              begin e_an = 4'b1101; e_seg = 7'b0100100; end
      checks++;
      if (an !== e_an || seg !== e_seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_seq k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=1", k, an, seg, dp, e_an, e_seg);
      end
    end
  endtask

  task automatic test_random();
    int low[4] = '{0, 0, 0, 0};
    for (int j = 0; j < 10 * FRAME; j++) begin
      if ($urandom_range(0, 11) == 0) begin
        digit0 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        digit1 = 4'($urandom); digit2 = 4'($urandom); digit3 = 4'($urandom);
        dp_en = 4'($urandom); blink_mask = 4'($urandom);
        blank_lead = 1'($urandom);
      end
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
        errors++;
        $display("FAIL random_model j=%0d an=%b seg=%b dp=%b expected %b %b %b", j, an, seg, dp, m_an, m_seg, m_dp);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL random_onehot j=%0d an=%b expected at most one low", j, an);
      end
      for (int i = 0; i < 4; i++) if (an[i] === 1'b0) low[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (low[i] != 10 * (SD - GD)) begin
        errors++;
        $display("FAIL random_duty anode=%0d low_cycles=%0d expected %0d", i, low[i], 10 * (SD - GD));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_frame();
    test_snapshot();
    test_blank_lead();
    test_blink();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
